json_drive_cmd_sender: RTL and testbench

- Parametrised successor to the fixed-string JSON drive sender.
- Accepts signed left/right wheel speeds over a valid/ready handshake and formats them at runtime as ASCII decimal into `{"T":<type>,"L":<l>,"R":<r>}\n`.
- Streams the message byte-by-byte through the existing uart_tx to the motor driver board.
- Sits between the waiter navigation FSM and the UART pin.

---
 rtl/json_drive_cmd_sender.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_json_drive_cmd_sender.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/json_drive_cmd_sender.sv
// Formats signed left/right wheel speeds as {"T":n,"L":l,"R":r}\n and streams the bytes out over UART.
// Define JSON_SENDER_HEARTBEAT_EN to resend the last command after HB_CYCLES idle cycles.

module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int BITS_N       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [BITS_N-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(BITS_N + 1);
   localparam logic [CW-1:0] TMR_LOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BITS_LOAD = BW'(BITS_N - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t         state;
   logic [CW-1:0]     bit_tmr;
   logic [BW-1:0]     bits_left;
   logic [BITS_N-1:0] shreg;

   assign tx_ready = (state == TX_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= TX_IDLE;
         bit_tmr   <= '0;
         bits_left <= '0;
         shreg     <= '0;
         tx        <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               if (tx_valid) begin
                  shreg   <= tx_data;
                  tx      <= 1'b0;
                  bit_tmr <= TMR_LOAD;
                  state   <= TX_START;
               end
            end
            TX_START: begin
               if (bit_tmr == '0) begin
                  tx        <= shreg[0];
                  shreg     <= shreg >> 1;
                  bits_left <= BITS_LOAD;
                  bit_tmr   <= TMR_LOAD;
                  state     <= TX_DATA;
               end else begin
                  bit_tmr <= bit_tmr - 1'b1;
               end
            end
            TX_DATA: begin
               if (bit_tmr == '0) begin
                  bit_tmr <= TMR_LOAD;
                  if (bits_left == '0) begin
                     tx    <= 1'b1;
                     state <= TX_STOP;
                  end else begin
                     tx        <= shreg[0];
                     shreg     <= shreg >> 1;
                     bits_left <= bits_left - 1'b1;
                  end
               end else begin
                  bit_tmr <= bit_tmr - 1'b1;
               end
            end
            default: begin
               if (bit_tmr == '0) state <= TX_IDLE;
               else               bit_tmr <= bit_tmr - 1'b1;
            end
         endcase
      end
   end
endmodule

// state  | meaning
// IDLE   | cmd_ready high, waiting for a command (or heartbeat expiry)
// CLAMP  | saturate latched speeds to MAX_MAG, update clamped flag
// CONV_L | left magnitude to decimal digits by repeated subtraction
// CONV_R | right magnitude to decimal digits
// EMIT   | walk the byte slots, handing each present byte to uart_tx
// DONE   | one-cycle done pulse
module json_drive_cmd_sender #(
   parameter int CLKS_PER_BIT = 434,
   parameter int BITS_N       = 8,
   parameter int VAL_W        = 10,
   parameter int MAX_MAG      = 255,
   parameter int CMD_TYPE     = 11,
   parameter int HB_CYCLES    = 25_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic signed [VAL_W-1:0] cmd_left,
   input  logic signed [VAL_W-1:0] cmd_right,
   output logic                    uart_out,
   output logic                    busy,
   output logic                    done,
   output logic                    clamped
);
   localparam logic [11:0] MAX_C    = 12'(MAX_MAG);
   localparam logic [9:0]  MAX_M    = 10'(MAX_MAG);
   localparam logic [3:0]  T_TENS   = 4'(CMD_TYPE / 10);
   localparam logic [3:0]  T_UNITS  = 4'(CMD_TYPE % 10);
   localparam logic [4:0]  LAST_SLOT = 5'd26;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CLAMP, ST_CONV_L, ST_CONV_R, ST_EMIT, ST_DONE
   } state_t;

   state_t            state;
   logic [VAL_W-1:0]  raw_l, raw_r;
   logic [9:0]        l_mag, r_mag;
   logic              l_neg, r_neg;
   logic [9:0]        w;
   logic [3:0]        dh, dt;
   logic [3:0]        l_h, l_t, l_u, r_h, r_t, r_u;
   logic [4:0]        slot;
   logic              tx_valid;
   logic [BITS_N-1:0] tx_data;
   logic              tx_ready;
   logic              accept;
   logic              hb_fire;

   logic [11:0] l_abs, r_abs;
   logic        l_over, r_over;
   logic [9:0]  l_clamp, r_clamp;
   logic        tens_last;
   logic [3:0]  conv_t, conv_u;
   logic [7:0]  slot_byte;
   logic        slot_ok;

   function automatic logic [11:0] abs_ext(input logic [VAL_W-1:0] v);
      logic [11:0] s;
      s = {{(12-VAL_W){v[VAL_W-1]}}, v};
      return s[11] ? (~s + 12'd1) : s;
   endfunction

   function automatic logic [7:0] dchar(input logic [3:0] d);
      return {4'h3, d};
   endfunction

   assign cmd_ready = (state == ST_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;

`ifdef JSON_SENDER_HEARTBEAT_EN
   localparam int HBW = $clog2(HB_CYCLES + 1);
   localparam logic [HBW-1:0] HB_LOAD = HBW'(HB_CYCLES - 1);
   logic [HBW-1:0] hb_tmr;

   assign hb_fire = (state == ST_IDLE) && (hb_tmr == '0);

   always_ff @(posedge clk) begin
      if (rst || state != ST_IDLE || accept) hb_tmr <= HB_LOAD;
      else if (hb_tmr != '0)                 hb_tmr <= hb_tmr - 1'b1;
   end
`else
   assign hb_fire = 1'b0;
`endif

   always_comb begin
      l_abs   = abs_ext(raw_l);
      r_abs   = abs_ext(raw_r);
      l_over  = l_abs > MAX_C;
      r_over  = r_abs > MAX_C;
      l_clamp = l_over ? MAX_M : l_abs[9:0];
      r_clamp = r_over ? MAX_M : r_abs[9:0];
   end

   // Conversion finishes once w < 20: at most one tens subtraction remains, folded into the final step.
   always_comb begin
      tens_last = (w >= 10'd10);
      conv_t    = dt + (tens_last ? 4'd1 : 4'd0);
      conv_u    = tens_last ? 4'(w - 10'd10) : w[3:0];
   end

   always_comb begin
      slot_byte = 8'h00;
      slot_ok   = 1'b1;
      case (slot)
         5'd0:  slot_byte = "{";
         5'd1:  slot_byte = "\"";
         5'd2:  slot_byte = "T";
         5'd3:  slot_byte = "\"";
         5'd4:  slot_byte = ":";
         5'd5:  begin slot_byte = dchar(T_TENS); slot_ok = (CMD_TYPE >= 10); end
         5'd6:  slot_byte = dchar(T_UNITS);
         5'd7:  slot_byte = ",";
         5'd8:  slot_byte = "\"";
         5'd9:  slot_byte = "L";
         5'd10: slot_byte = "\"";
         5'd11: slot_byte = ":";
         5'd12: begin slot_byte = "-"; slot_ok = l_neg && (l_mag != '0); end
         5'd13: begin slot_byte = dchar(l_h); slot_ok = (l_h != '0); end
         5'd14: begin slot_byte = dchar(l_t); slot_ok = (l_h != '0) || (l_t != '0); end
         5'd15: slot_byte = dchar(l_u);
         5'd16: slot_byte = ",";
         5'd17: slot_byte = "\"";
         5'd18: slot_byte = "R";
         5'd19: slot_byte = "\"";
         5'd20: slot_byte = ":";
         5'd21: begin slot_byte = "-"; slot_ok = r_neg && (r_mag != '0); end
         5'd22: begin slot_byte = dchar(r_h); slot_ok = (r_h != '0); end
         5'd23: begin slot_byte = dchar(r_t); slot_ok = (r_h != '0) || (r_t != '0); end
         5'd24: slot_byte = dchar(r_u);
         5'd25: slot_byte = "}";
         5'd26: slot_byte = 8'h0A;
         default: slot_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         raw_l    <= '0;
         raw_r    <= '0;
         l_mag    <= '0;
         r_mag    <= '0;
         l_neg    <= 1'b0;
         r_neg    <= 1'b0;
         w        <= '0;
         dh       <= '0;
         dt       <= '0;
         l_h      <= '0;
         l_t      <= '0;
         l_u      <= '0;
         r_h      <= '0;
         r_t      <= '0;
         r_u      <= '0;
         slot     <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         clamped  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  raw_l <= cmd_left;
                  raw_r <= cmd_right;
                  busy  <= 1'b1;
                  state <= ST_CLAMP;
               end else if (hb_fire) begin
                  // Resend uses the stored, already-clamped magnitudes.
                  w     <= l_mag;
                  dh    <= '0;
                  dt    <= '0;
                  busy  <= 1'b1;
                  state <= ST_CONV_L;
               end
            end
            ST_CLAMP: begin
               l_mag   <= l_clamp;
               r_mag   <= r_clamp;
               l_neg   <= raw_l[VAL_W-1];
               r_neg   <= raw_r[VAL_W-1];
               clamped <= l_over || r_over;
               w       <= l_clamp;
               dh      <= '0;
               dt      <= '0;
               state   <= ST_CONV_L;
            end
            ST_CONV_L, ST_CONV_R: begin
               if (w >= 10'd100) begin
                  w  <= w - 10'd100;
                  dh <= dh + 4'd1;
               end else if (w >= 10'd20) begin
                  w  <= w - 10'd10;
                  dt <= dt + 4'd1;
               end else if (state == ST_CONV_L) begin
                  l_h   <= dh;
                  l_t   <= conv_t;
                  l_u   <= conv_u;
                  w     <= r_mag;
                  dh    <= '0;
                  dt    <= '0;
                  state <= ST_CONV_R;
               end else begin
                  r_h      <= dh;
                  r_t      <= conv_t;
                  r_u      <= conv_u;
                  slot     <= '0;
                  tx_valid <= 1'b0;
                  state    <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (tx_valid) begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     if (slot == LAST_SLOT) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                     end else begin
                        slot <= slot + 5'd1;
                     end
                  end
               end else if (!slot_ok) begin
                  slot <= slot + 5'd1;
               end else if (tx_ready) begin
                  tx_valid <= 1'b1;
                  tx_data  <= BITS_N'(slot_byte);
               end
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .BITS_N      (BITS_N)
   ) u_uart_tx (
      .clk     (clk),
      .rst     (rst),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .tx      (uart_out)
   );
endmodule

// File: tb/tb_json_drive_cmd_sender.sv
// Scoreboard bench: expected UART bytes are queued per command; a serial monitor decodes and compares.
module tb_json_drive_cmd_sender;
   localparam int CPB   = 8;
   localparam int VAL_W = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid = 1'b0;
   logic signed [VAL_W-1:0] cmd_left = '0;
   logic signed [VAL_W-1:0] cmd_right = '0;
   logic cmd_ready, uart_out, busy, done, clamped;

   int  n_checks = 0;
   int  n_pass = 0;
   byte exp_q[$];
   int  done_cnt = 0;
   int  rx_bytes = 0;
   logic rx_busy = 1'b0;
   int  rx_cnt = 0;
   int  rx_bit = 0;
   logic [7:0] rx_sh = '0;

   always #5 clk = ~clk;

   json_drive_cmd_sender #(
      .CLKS_PER_BIT(CPB),
      .BITS_N      (8),
      .VAL_W       (VAL_W),
      .MAX_MAG     (255),
      .CMD_TYPE    (11),
      .HB_CYCLES   (2000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_left (cmd_left),
      .cmd_right(cmd_right),
      .uart_out (uart_out),
      .busy     (busy),
      .done     (done),
      .clamped  (clamped)
   );

   function automatic void check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
   endfunction

   function automatic string mk(input int l, input int r);
      return $sformatf("{\"T\":11,\"L\":%0d,\"R\":%0d}\n", l, r);
   endfunction

   task automatic push_msg(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   // Serial monitor: samples mid-bit, pops one expected byte per received frame.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (rst) begin
         rx_busy = 1'b0;
      end else if (!rx_busy) begin
         if (!uart_out) begin
            rx_busy = 1'b1;
            rx_cnt  = CPB / 2;
            rx_bit  = 0;
         end
      end else begin
         rx_cnt--;
         if (rx_cnt == 0) begin
            rx_cnt = CPB;
            if (rx_bit == 0) begin
               check("start_bit", int'(uart_out), 0);
            end else if (rx_bit <= 8) begin
               rx_sh = {uart_out, rx_sh[7:1]};
            end else begin
               check("stop_bit", int'(uart_out), 1);
               rx_busy = 1'b0;
               rx_bytes++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL extra_byte: got 0x%02h expected no byte", rx_sh);
               end else begin
                  check("uart_byte", int'(rx_sh), int'(exp_q.pop_front()));
               end
            end
            rx_bit++;
         end
      end
   end

   task automatic send_cmd(input int l, input int r);
      int guard;
      guard = 0;
      @(negedge clk);
      cmd_left  = VAL_W'(l);
      cmd_right = VAL_W'(r);
      cmd_valid = 1'b1;
      while (!cmd_ready && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) begin
         n_checks++;
         $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, guard);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic finish_msg(input int base, input int pulses, input int exp_clamped);
      int guard;
      guard = 0;
      while ((done_cnt - base < pulses || exp_q.size() != 0 || rx_busy) && guard < 10000) begin
         @(negedge clk);
         guard++;
      end
      check("done_pulses", done_cnt - base, pulses);
      check("queue_drained", exp_q.size(), 0);
      check("ready_after_done", int'(cmd_ready), 1);
      check("busy_after_done", int'(busy), 0);
      check("clamped", int'(clamped), exp_clamped);
   endtask

   // l, r, expected L, expected R, expected clamped
   int vec [0:8][0:4] = '{
      '{ 164,  164,  164,  164, 0},
      '{-300,    0, -255,    0, 1},
      '{   5,   -7,    5,   -7, 0},
      '{-512,   -1, -255,   -1, 1},
      '{   0,    0,    0,    0, 0},
      '{ 255, -255,  255, -255, 0},
      '{ 256,  100,  255,  100, 1},
      '{ 511,  -10,  255,  -10, 1},
      '{   9,  -99,    9,  -99, 0}
   };

   initial begin
      int base;
      int start_bytes;
      int guard;

      repeat (3) @(negedge clk);
      check("ready_in_reset", int'(cmd_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ready", int'(cmd_ready), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_clamped", int'(clamped), 0);
      check("reset_uart_idle", int'(uart_out), 1);

      for (int i = 0; i < 9; i++) begin
         push_msg(mk(vec[i][2], vec[i][3]));
         base = done_cnt;
         send_cmd(vec[i][0], vec[i][1]);
         check("ready_drops", int'(cmd_ready), 0);
         check("busy_set", int'(busy), 1);
         finish_msg(base, 1, vec[i][4]);
      end

      // Second command held on cmd_valid during the first transmission.
      push_msg(mk(20, -30));
      push_msg(mk(7, 8));
      base = done_cnt;
      send_cmd(20, -30);
      send_cmd(7, 8);
      check("held_cmd_after_done", done_cnt - base, 1);
      finish_msg(base, 2, 0);

      // Reset while the 10th byte is on the wire.
      push_msg(mk(164, 164));
      base = done_cnt;
      start_bytes = rx_bytes;
      send_cmd(164, 164);
      guard = 0;
      while (rx_bytes - start_bytes < 9 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("bytes_before_reset", rx_bytes - start_bytes, 9);
      repeat (3 * CPB) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_reset_uart_high", int'(uart_out), 1);
      check("mid_reset_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("mid_reset_no_done", done_cnt - base, 0);
      check("mid_reset_ready", int'(cmd_ready), 1);
      check("mid_reset_line_idle", int'(uart_out), 1);

      push_msg(mk(1, 2));
      base = done_cnt;
      send_cmd(1, 2);
      finish_msg(base, 1, 0);

`ifdef JSON_SENDER_HEARTBEAT_EN
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      push_msg(mk(0, 0));
      base = done_cnt;
      rst = 1'b0;
      finish_msg(base, 1, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end
endmodule
